// File: rtl/self_attention_seq_ctrl.sv
// Sequencing controller for the self-attention head.
// It gathers slice-done events from NUM_INST block-to-row converters.
// It then streams TILES_PER_ROW tiles of ROWS parallel softmax rows under
// backpressure, pulses a converter reset, and repeats this for NUM_BLOCKS
// blocks before it pulses done.
module self_attention_seq_ctrl #(
    parameter int NUM_INST      = 1,
    parameter int ROWS          = 4,
    parameter int TILES_PER_ROW = 4,
    parameter int NUM_BLOCKS    = 8,
    localparam int TW = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1,
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_INST-1:0] slice_done,
    input  logic [NUM_INST-1:0] out_ready_b2r,
    input  logic                softmax_ready,
    output logic                internal_rst_b2r,
    output logic                softmax_en,
    output logic [ROWS-1:0]     softmax_valid,
    output logic [TW-1:0]       tile_idx,
    output logic [BW-1:0]       block_idx,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATHER = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [TW-1:0] TILE_LAST  = TW'(TILES_PER_ROW - 1);
    localparam logic [BW-1:0] BLOCK_LAST = BW'(NUM_BLOCKS - 1);

    // True when every converter instance has reported its slice.
    function automatic logic all_set(input logic [NUM_INST-1:0] m);
        return &m;
    endfunction

    state_t              state_r, state_s;
    logic [TW-1:0]       tile_cnt_r, tile_cnt_s;
    logic [BW-1:0]       block_cnt_r, block_cnt_s;
    logic [NUM_INST-1:0] mask_r, mask_s;
    logic                err_r, err_s;
    logic                en_r, busy_r, done_r, flush_r;
    logic [NUM_INST-1:0] merged_s;
    logic                overlap_s;
    logic                xfer_s;

    // Next-state, counter, gather-mask and overrun logic.
    always_comb begin
        state_s     = state_r;
        tile_cnt_s  = tile_cnt_r;
        block_cnt_s = block_cnt_r;
        mask_s      = mask_r;
        err_s       = err_r;
        merged_s    = mask_r | slice_done;
        overlap_s   = |(slice_done & mask_r);
        xfer_s      = (&out_ready_b2r) && softmax_ready;

        case (state_r)
            ST_IDLE: begin
                // slice_done in IDLE is dropped without flagging an overrun.
                if (start) begin
                    state_s     = ST_GATHER;
                    tile_cnt_s  = {TW{1'b0}};
                    block_cnt_s = {BW{1'b0}};
                    mask_s      = {NUM_INST{1'b0}};
                    err_s       = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GATHER: begin
                if (overlap_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (all_set(merged_s)) begin
                    state_s = ST_STREAM;
                    mask_s  = {NUM_INST{1'b0}};
                end else begin
                    mask_s  = merged_s;
                end
            end
            ST_STREAM: begin
                // Early slices for the next block pre-load the mask.
                if (overlap_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                mask_s = merged_s;
                if (xfer_s) begin
                    if (tile_cnt_r == TILE_LAST) begin
                        tile_cnt_s = {TW{1'b0}};
                        state_s    = ST_FLUSH;
                    end else begin
                        tile_cnt_s = tile_cnt_r + TW'(1);
                    end
                end else begin
                    tile_cnt_s = tile_cnt_r;
                end
            end
            ST_FLUSH: begin
                if (overlap_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                mask_s = merged_s;
                if (block_cnt_r == BLOCK_LAST) begin
                    block_cnt_s = {BW{1'b0}};
                    state_s     = ST_DONE;
                end else begin
                    block_cnt_s = block_cnt_r + BW'(1);
                    state_s     = ST_GATHER;
                end
            end
            ST_DONE: begin
                if (overlap_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                tile_cnt_s  = {TW{1'b0}};
                block_cnt_s = {BW{1'b0}};
                mask_s      = {NUM_INST{1'b0}};
                err_s       = 1'b0;
            end
        endcase
    end

    // State, counters, mask and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            tile_cnt_r  <= {TW{1'b0}};
            block_cnt_r <= {BW{1'b0}};
            mask_r      <= {NUM_INST{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            tile_cnt_r  <= tile_cnt_s;
            block_cnt_r <= block_cnt_s;
            mask_r      <= mask_s;
            err_r       <= err_s;
        end
    end

    // Moore outputs are registered from the next state, so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            flush_r <= 1'b0;
        end else begin
            en_r    <= (state_s == ST_STREAM);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            flush_r <= (state_s == ST_FLUSH);
        end
    end

    // Valid is the one Mealy output: it follows the converters' live ready level.
    assign softmax_valid    = {ROWS{en_r & (&out_ready_b2r)}};
    assign softmax_en       = en_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign internal_rst_b2r = flush_r;
    assign tile_idx         = tile_cnt_r;
    assign block_idx        = block_cnt_r;
    assign err              = err_r;

endmodule
